// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default baud divisor and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned CLKS_PER_BIT_115200 = 868;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate divider: counts 0..CLKS_PER_BIT-1 and emits a one-cycle tick on the wrap cycle.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == LAST_CNT);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A cleared counter never ticks, so a frame always starts at phase zero.
    assign o_tick = w_wrap && !i_clr;

endmodule

// File: rtl/uart_transmit.sv
// UART transmitter, 8N1 by default, LSB first, valid/ready byte input.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_transmit
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic                 o_tx,
    output logic                 o_busy
);

    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    uart_state_e          r_state, w_state_d;
    logic [DATA_BITS-1:0] r_shreg, w_shreg_d;
    logic [BIT_W-1:0]     r_bit_cnt, w_bit_cnt_d;
    logic                 r_tx, w_tx_d;
    logic                 w_tick;
    logic                 w_baud_clr;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity, w_parity_d;
`endif

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clr  (w_baud_clr),
        .o_tick (w_tick)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_d;
            r_shreg   <= w_shreg_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_tx      <= w_tx_d;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity_d;
`endif
        end
    end

    // w_tx_d is the line level of the state being entered, so the pin stays registered.
    always_comb begin
        w_state_d   = r_state;
        w_shreg_d   = r_shreg;
        w_bit_cnt_d = r_bit_cnt;
        w_tx_d      = r_tx;
        w_baud_clr  = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_d  = r_parity;
`endif
        unique case (r_state)
            ST_IDLE: begin
                w_baud_clr = 1'b1;
                w_tx_d     = LINE_IDLE;
                if (i_tx_valid) begin
                    w_shreg_d   = i_tx_data;
                    w_bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    w_parity_d  = ^i_tx_data;
`endif
                    w_state_d   = ST_START;
                    w_tx_d      = START_BIT;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_d = ST_DATA;
                    w_tx_d    = r_shreg[0];
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shreg_d = r_shreg >> 1;
                    if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_state_d = ST_PARITY;
                        w_tx_d    = r_parity;
`else
                        w_state_d = ST_STOP;
                        w_tx_d    = LINE_IDLE;
`endif
                    end else begin
                        w_bit_cnt_d = r_bit_cnt + 1'b1;
                        w_tx_d      = r_shreg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_d = ST_STOP;
                    w_tx_d    = LINE_IDLE;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    w_state_d = ST_IDLE;
                    w_tx_d    = LINE_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_tx_d    = LINE_IDLE;
            end
        endcase
    end

    assign o_tx_ready = (r_state == ST_IDLE);
    assign o_busy     = (r_state != ST_IDLE);
    assign o_tx       = r_tx;

endmodule

// File: tb/tb_uart_transmit.sv
// Directed bench for uart_transmit: per-bit line checks against hand-computed frames,
// plus a loopback receive model whose recovered bytes are compared at the end.
module tb_uart_transmit;

    localparam int unsigned CPB = 868;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_transmit #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_tx_data (tx_data),
        .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready),
        .o_tx      (tx),
        .o_busy    (busy)
    );

    // Frame bit i (bit 0 = start) is expected at line bit-time i.
    typedef struct {
        logic [7:0]  data;
        logic [7:0]  data_after;
        bit          hold;
        logic [10:0] frame;
        string       name;
    } vec_t;

    vec_t tbl[5];
    logic [10:0] fr_41;
    logic [7:0]  exp_rx[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entry: at a negedge with the byte and tx_valid already driven. Exit: negedge of the
    // first IDLE cycle after the frame.
    task automatic check_frame(input logic [7:0] d_after, input bit hold,
                               input logic [10:0] fr, input string tag);
        int rdy_cnt  = 0;
        int busy_cnt = 0;
        chk({tag, "_ready_pre"}, {31'd0, tx_ready}, 32'd1);
        @(posedge clk);
        #1;
        tx_data  = d_after;
        tx_valid = hold;
        for (int c = 0; c < int'(NB * CPB); c++) begin
            @(negedge clk);
            if ((c % CPB) == 0 || (c % CPB) == CPB - 1) begin
                chk($sformatf("%s_bit%0d_c%0d", tag, c / CPB, c % CPB), {31'd0, tx},
                    {31'd0, fr[c / CPB]});
            end
            if (tx_ready) rdy_cnt++;
            if (busy) busy_cnt++;
        end
        chk({tag, "_ready_in_frame"}, rdy_cnt, 0);
        chk({tag, "_busy_cycles"}, busy_cnt, NB * CPB);
        @(negedge clk);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_ready_end"}, {31'd0, tx_ready}, 32'd1);
        chk({tag, "_tx_end"}, {31'd0, tx}, 32'd1);
    endtask

    // Loopback receiver: samples at bit centres, drops frames interrupted by reset.
    logic       rx_act = 1'b0;
    int         rx_c   = 0;
    logic [7:0] rx_sh  = '0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act <= 1'b1;
                rx_c   <= 1;
            end
        end else begin
            rx_c <= rx_c + 1;
            if ((rx_c % CPB) == CPB / 2) begin
                if (rx_c / CPB == 0) begin
                    if (tx !== 1'b0) rx_act <= 1'b0;
                end else if (rx_c / CPB <= 8) begin
                    rx_sh[rx_c / CPB - 1] <= tx;
                end else if (rx_c / CPB == int'(NB - 1)) begin
                    rx_act <= 1'b0;
                    if (tx === 1'b1) rx_q.push_back(rx_sh);
                end
            end
        end
    end

    initial begin
`ifdef UART_TX_PARITY_EN
        tbl[0] = '{8'h30, 8'h30, 1'b0, 11'h460, "single_30"};
        tbl[1] = '{8'h55, 8'hA3, 1'b1, 11'h4AA, "b2b_55"};
        tbl[2] = '{8'hA3, 8'hA3, 1'b0, 11'h546, "b2b_a3"};
        tbl[3] = '{8'h00, 8'hFF, 1'b0, 11'h400, "stable_00"};
        tbl[4] = '{8'h31, 8'h31, 1'b0, 11'h662, "single_31"};
        fr_41  = 11'h482;
`else
        tbl[0] = '{8'h30, 8'h30, 1'b0, 11'h260, "single_30"};
        tbl[1] = '{8'h55, 8'hA3, 1'b1, 11'h2AA, "b2b_55"};
        tbl[2] = '{8'hA3, 8'hA3, 1'b0, 11'h346, "b2b_a3"};
        tbl[3] = '{8'h00, 8'hFF, 1'b0, 11'h200, "stable_00"};
        tbl[4] = '{8'h31, 8'h31, 1'b0, 11'h262, "single_31"};
        fr_41  = 11'h282;
`endif
        exp_rx = '{8'h30, 8'h55, 8'hA3, 8'h00, 8'h31, 8'h41};

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_ready", {31'd0, tx_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        begin
            int idle_hi = 0;
            repeat (20) begin
                @(negedge clk);
                if (tx && !busy) idle_hi++;
            end
            chk("idle_no_valid", idle_hi, 20);
        end

        for (int i = 0; i < 5; i++) begin
            if (i == 0 || !tbl[i - 1].hold) begin
                @(negedge clk);
                tx_data  = tbl[i].data;
                tx_valid = 1'b1;
            end else begin
                tx_data = tbl[i].data;
            end
            check_frame(tbl[i].data_after, tbl[i].hold, tbl[i].frame, tbl[i].name);
        end

        // Reset during data bit 4 of 0x0F (line low there).
        @(negedge clk);
        tx_data  = 8'h0F;
        tx_valid = 1'b1;
        chk("rst_mid_ready_pre", {31'd0, tx_ready}, 32'd1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        for (int c = 0; c <= int'(5 * CPB + CPB / 4); c++) @(negedge clk);
        chk("rst_mid_tx_pre", {31'd0, tx}, 32'd0);
        chk("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_tx", {31'd0, tx}, 32'd1);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_ready", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        tx_data  = 8'h41;
        tx_valid = 1'b1;
        check_frame(8'h41, 1'b0, fr_41, "after_rst_41");

        repeat (4) @(negedge clk);
        chk("rx_count", rx_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < rx_q.size()) begin
                chk($sformatf("rx_byte%0d", i), {24'd0, rx_q[i]}, {24'd0, exp_rx[i]});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
